shift_add_multiplier: RTL and testbench

- Sequential unsigned shift-and-add multiplier: N-bit multiplicand × N-bit multiplier → 2N-bit product.
- Owns no adder. It drives augend/addend ports to an external combinational 2N-bit adder (the team's `Adder`, carry unused) and reads back the sum.
- Used wherever a slow, area-cheap multiply is acceptable; the adder can be shared at the integration level.

---
 rtl/shift_add_multiplier_pkg.sv | 22 ++
 rtl/shift_add_multiplier.sv | 109 ++++++++++
 tb/tb_shift_add_multiplier.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/shift_add_multiplier_pkg.sv
// Shared definitions for the shift-and-add multiplier.
//   state_t : FSM state encoding (idle, iterating, result held)
//   clog2   : ceiling log2, used to size the iteration counter
package shift_add_multiplier_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_t;

    // Returns ceil(log2(value)); 0 for value <= 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width;
        width = 0;
        while ((64'd1 << width) < 64'(value)) begin
            width = width + 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-and-add multiplier, N x N -> 2N bits, N+1 cycles per result.
// The block owns no adder: it drives an external combinational 2N-bit adder and
// accumulates the returned sum, so the adder can be shared at integration.
// Ports:
//   i_clock, i_reset         : clock, asynchronous active-high reset
//   i_start                  : start request (ignored while iterating)
//   i_multiplicand, i_multiplier : operands, sampled on the start edge
//   o_finished               : high while a completed result is held
//   o_product                : registered result, updated only on the last iteration
//   o_adder_augend/addend    : operands to the external adder (0 when not iterating)
//   i_adder_sum              : combinational sum from the external adder
module shift_add_multiplier
    import shift_add_multiplier_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic           i_clock,
    input  logic           i_reset,
    input  logic           i_start,
    output logic           o_finished,
    input  logic [N-1:0]   i_multiplicand,
    input  logic [N-1:0]   i_multiplier,
    output logic [2*N-1:0] o_product,
    output logic [2*N-1:0] o_adder_augend,
    output logic [2*N-1:0] o_adder_addend,
    input  logic [2*N-1:0] i_adder_sum
);

    localparam int unsigned CountWidth = clog2(N) + 1;
    localparam logic [CountWidth-1:0] LastCount = CountWidth'(N - 1);

    state_t                state_q;
    logic [2*N-1:0]        acc_q;
    logic [2*N-1:0]        mcand_sh_q;
    logic [N-1:0]          mplier_sh_q;
    logic [CountWidth-1:0] count_q;

    logic load;
    logic last_iter;

    // A new operation may begin from either idle or a held result.
    assign load      = (state_q != StRun) && i_start;
    assign last_iter = (state_q == StRun) && (count_q == LastCount);

    // Control FSM with registered outputs.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= StIdle;
            o_finished <= 1'b0;
            o_product  <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (i_start) begin
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    if (last_iter) begin
                        state_q    <= StDone;
                        o_finished <= 1'b1;
                        o_product  <= i_adder_sum;
                    end
                end
                StDone: begin
                    if (i_start) begin
                        state_q    <= StRun;
                        o_finished <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= StIdle;
                    o_finished <= 1'b0;
                end
            endcase
        end
    end

    // Datapath registers: operand shifters, accumulator, iteration counter.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            acc_q       <= '0;
            mcand_sh_q  <= '0;
            mplier_sh_q <= '0;
            count_q     <= '0;
        end else if (load) begin
            acc_q       <= '0;
            mcand_sh_q  <= {{N{1'b0}}, i_multiplicand};
            mplier_sh_q <= i_multiplier;
            count_q     <= '0;
        end else if (state_q == StRun) begin
            acc_q       <= i_adder_sum;
            mcand_sh_q  <= mcand_sh_q << 1;
            mplier_sh_q <= mplier_sh_q >> 1;
            count_q     <= count_q + 1'b1;
        end
    end

    // Adder drive: quiet outside RUN so a shared adder sees no activity from us.
    always_comb begin
        o_adder_augend = '0;
        o_adder_addend = '0;
        if (state_q == StRun) begin
            o_adder_augend = acc_q;
            o_adder_addend = mplier_sh_q[0] ? mcand_sh_q : '0;
        end
    end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed self-checking bench for shift_add_multiplier (N=4) with a behavioural adder.
module tb_shift_add_multiplier;

    localparam int unsigned N = 4;

    logic           clock;
    logic           reset;
    logic           start;
    logic           finished;
    logic [N-1:0]   multiplicand;
    logic [N-1:0]   multiplier;
    logic [2*N-1:0] product;
    logic [2*N-1:0] adder_augend;
    logic [2*N-1:0] adder_addend;
    logic [2*N-1:0] adder_sum;

    int n_vectors;
    int n_miscompares;

    // External combinational adder, carry discarded.
    assign adder_sum = adder_augend + adder_addend;

    shift_add_multiplier #(.N(N)) dut (
        .i_clock        (clock),
        .i_reset        (reset),
        .i_start        (start),
        .o_finished     (finished),
        .i_multiplicand (multiplicand),
        .i_multiplier   (multiplier),
        .o_product      (product),
        .o_adder_augend (adder_augend),
        .o_adder_addend (adder_addend),
        .i_adder_sum    (adder_sum)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        n_vectors = n_vectors + 1;
        if (observed !== expected) begin
            n_miscompares = n_miscompares + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic check_idle_adder(input string tag);
        check({tag, ".augend"}, 32'(adder_augend), 32'd0);
        check({tag, ".addend"}, 32'(adder_addend), 32'd0);
    endtask

    // Start one operation and follow it to completion, checking the latency and
    // that o_product holds prev until the final iteration. With glitch set, a
    // second start with junk operands is applied at cycle 2 and must be ignored.
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [2*N-1:0] prev, input bit glitch);
        logic [31:0] expected;
        expected = 32'(a) * 32'(b);
        @(negedge clock);
        start        = 1'b1;
        multiplicand = a;
        multiplier   = b;
        @(posedge clock);
        #1;
        check("start.finished", 32'(finished), 32'd0);
        check("start.product", 32'(product), 32'(prev));
        @(negedge clock);
        start        = 1'b0;
        multiplicand = ~a;
        multiplier   = ~b;
        for (int i = 1; i <= int'(N); i++) begin
            @(posedge clock);
            #1;
            if (i < int'(N)) begin
                check("run.finished", 32'(finished), 32'd0);
                check("run.product", 32'(product), 32'(prev));
            end else begin
                check("done.finished", 32'(finished), 32'd1);
                check("done.product", 32'(product), expected);
                check_idle_adder("done");
            end
            if (glitch && i == 1) begin
                start        = 1'b1;
                multiplicand = 4'd1;
                multiplier   = 4'd1;
            end else begin
                start = 1'b0;
            end
        end
    endtask

    initial begin
        logic [2*N-1:0] prev;
        n_vectors     = 0;
        n_miscompares = 0;
        start         = 1'b0;
        multiplicand  = '0;
        multiplier    = '0;
        reset         = 1'b1;
        #12;
        check("reset.finished", 32'(finished), 32'd0);
        check("reset.product", 32'(product), 32'd0);
        check_idle_adder("reset");
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        check("idle.finished", 32'(finished), 32'd0);
        check_idle_adder("idle");

        run_op(4'd3, 4'd5, 8'd0, 1'b0);
        run_op(4'd15, 4'd15, 8'd15, 1'b0);
        run_op(4'd0, 4'd9, 8'd225, 1'b0);
        run_op(4'd1, 4'd15, 8'd0, 1'b0);
        run_op(4'd7, 4'd6, 8'd15, 1'b1);
        // Result held indefinitely in DONE.
        repeat (3) @(posedge clock);
        #1;
        check("hold.finished", 32'(finished), 32'd1);
        check("hold.product", 32'(product), 32'd42);
        run_op(4'd2, 4'd3, 8'd42, 1'b0);

        // Reset in the middle of a run, away from a clock edge.
        @(negedge clock);
        start        = 1'b1;
        multiplicand = 4'd5;
        multiplier   = 4'd5;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        check("midreset.finished", 32'(finished), 32'd0);
        check("midreset.product", 32'(product), 32'd0);
        check_idle_adder("midreset");
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        check("postreset.finished", 32'(finished), 32'd0);
        check_idle_adder("postreset");
        run_op(4'd4, 4'd4, 8'd0, 1'b0);

        // Exhaustive operand sweep.
        prev = 8'd16;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                run_op(4'(a), 4'(b), prev, 1'b0);
                prev = 8'(a * b);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
